pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Generic parametrised pipeline stage register for the mycpu pipeline.
- Successor to the fixed per-stage registers with rst/bubble-only control.
- Carries an opaque payload (operands, PC, instr, predictor info) plus a control bundle that is zeroed on bubble/flush, under a valid/ready handshake with flush priority.
- Also provides a saturating stall-cycle counter for performance analysis; sits between any two stages (D->E, E->M, M->W).

Parameters:
- DATA_W, 128: payload width; never cleared except at reset.
- CTRL_W, 48: control-info width (opcode/alu/branch/ls/csr/wen/rd); zeroed on bubble/flush.
- CNT_W, 16: stall-counter width; saturates at all-ones.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- up_valid_i  in  1  upstream stage has a valid instruction.
- up_ready_o  out  1  this register can accept this cycle.
- up_data_i  in  DATA_W  upstream payload.
- up_ctrl_i  in  CTRL_W  upstream control bundle.
- flush_i  in  1  kill held and incoming instruction (mispredict/redirect).
- dn_valid_o  out  1  register holds a valid instruction.
- dn_ready_i  in  1  downstream accepts this cycle.
- dn_data_o  out  DATA_W  held payload.
- dn_ctrl_o  out  CTRL_W  held control; all-zero whenever dn_valid_o=0.
- stall_cnt_o  out  CNT_W  cycles with dn_valid_o=1 and dn_ready_i=0, saturating.
- cnt_clr_i  in  1  synchronous clear of stall_cnt_o.

Behaviour:
- Reset (rst_n=0, async): dn_valid_o=0, dn_data_o=0, dn_ctrl_o=0, stall_cnt_o=0, internal skid entry empty. Deassertion is used synchronously at the next clk edge.
- Transfers:
  - Upstream transfer occurs when up_valid_i & up_ready_o.
  - Downstream transfer occurs when dn_valid_o & dn_ready_i.
- Base mode (no skid):
  - up_ready_o = ~dn_valid_o | dn_ready_i (combinational pass-through of dn_ready_i).
  - On an upstream transfer, the next cycle has dn_valid_o=1 and dn_data_o/dn_ctrl_o equal to the captured values; latency is 1 cycle.
  - Downstream transfer with no upstream transfer: dn_valid_o<=0, dn_ctrl_o<=0 (bubble); dn_data_o holds its value.
  - dn_valid_o & ~dn_ready_i: all outputs hold (stall). Upstream inputs are ignored because up_ready_o=0.
- Flush:
  - flush_i=1 at an edge: dn_valid_o<=0, dn_ctrl_o<=0, skid entry emptied.
  - Any simultaneous upstream transfer is discarded.
  - up_ready_o is unaffected by flush_i.
  - Flush has priority over every other event except reset.
- Invariant: dn_valid_o=0 implies dn_ctrl_o=0, so downstream write-enables can never fire from a bubble.
- Stall counter:
  - Increments by 1 each edge where dn_valid_o & ~dn_ready_i & ~flush_i.
  - Holds at 2^CNT_W-1.
  - cnt_clr_i wins over increment and sets the counter to 0.
  - Not cleared by flush_i.
- Back-to-back: with dn_ready_i=1 held and up_valid_i=1 held, one instruction transfers per cycle with no bubbles.

Optional Feature:
- Macro: PIPE_STAGE_SKID_EN.
- Defined:
  - A one-entry skid buffer is added.
  - up_ready_o is registered and equals ~skid_valid, so there is no combinational path from dn_ready_i to up_ready_o.
  - An upstream transfer while the main entry is stalled goes into the skid entry.
  - When the main entry drains, the skid entry moves to main in the same edge.
  - Ordering is strictly FIFO. Flush empties both entries.
  - Throughput remains 1/cycle; latency remains 1 cycle when the skid entry is empty.
- Undefined: base mode exactly as above; no skid storage is synthesised.

Decomposition:
- Shared package (pipe_pkg): default widths, ctrl-field bit offsets (opcode/alu/branch/ls/csr/wen/rd), the zero-control constant CTRL_BUBBLE, and the reg_wen_no_w encoding.
- One natural sub-module: pipe_stall_counter (saturating counter with clear), reused by other stages' performance logic.
- Skid logic stays inline under the macro.

Test Plan:
- Reset mid-operation: dn_valid_o=1 with data 0xA5.., ctrl 0x3F; assert rst_n=0 between edges -> dn_valid_o, dn_ctrl_o, dn_data_o, stall_cnt_o read 0 immediately, without waiting for clk.
- Streaming: 8 back-to-back instrs with ctrl=1..8 and dn_ready_i=1 -> dn_ctrl_o shows 1..8 on consecutive cycles, 1-cycle latency, stall_cnt_o=0.
- Stall: hold dn_ready_i=0 for 5 cycles with dn_valid_o=1 -> outputs frozen, up_ready_o=0 (base) and stall_cnt_o=5. With SKID_EN, one extra instr is accepted, then up_ready_o=0 and ordering is preserved on release.
- Flush with simultaneous upstream transfer: flush_i=1 and up_valid_i=1 with ctrl=0x12 -> next cycle dn_valid_o=0, dn_ctrl_o=0; the instr is not seen downstream.
- Saturation/clear: CNT_W=4, stall 20 cycles -> stall_cnt_o=15. Then cnt_clr_i and stall asserted in the same cycle -> 0 on the next cycle, 1 on the cycle after.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for mycpu pipeline stage registers: default widths,
// control-bundle field layout, the bubble (all-zero) control word and the
// "no register write" encoding of the write-enable field.
package pipe_pkg;

    localparam int DATA_W_DEF = 128;
    localparam int CTRL_W_DEF = 48;
    localparam int CNT_W_DEF  = 16;

    // Control-bundle field layout (LSB offset / width). Bits 43..47 are reserved.
    localparam int CTRL_OPCODE_LSB = 0;
    localparam int CTRL_OPCODE_W   = 7;
    localparam int CTRL_ALU_LSB    = 7;
    localparam int CTRL_ALU_W      = 6;
    localparam int CTRL_BR_LSB     = 13;
    localparam int CTRL_BR_W       = 4;
    localparam int CTRL_LS_LSB     = 17;
    localparam int CTRL_LS_W       = 5;
    localparam int CTRL_CSR_LSB    = 22;
    localparam int CTRL_CSR_W      = 15;
    localparam int CTRL_WEN_LSB    = 37;
    localparam int CTRL_RD_LSB     = 38;
    localparam int CTRL_RD_W       = 5;

    // A bubble carries an all-zero control word, so every enable is off.
    localparam logic [CTRL_W_DEF-1:0] CTRL_BUBBLE = '0;

    // Write-enable value meaning "this instruction does not write rd".
    localparam logic REG_WEN_NO_W = 1'b0;

    // Extract the register write-enable bit from a control word.
    function automatic logic ctrl_reg_wen(input logic [CTRL_W_DEF-1:0] ctrl);
        return ctrl[CTRL_WEN_LSB];
    endfunction

endpackage

// File: rtl/pipe_stall_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
// Used for per-stage stall-cycle performance counts.
module pipe_stall_counter
    import pipe_pkg::*;
#(
    parameter int W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear first, otherwise increment until all-ones and hold there.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register, asynchronously cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: opaque payload plus a control bundle that
// is zeroed whenever the stage holds a bubble. Flush beats everything but reset.
// Handshake: a transfer happens on an edge where valid and ready are both high;
// valid never depends on ready, and the payload is stable while stalled.
// Optional macro PIPE_STAGE_SKID_EN adds a one-entry skid buffer and makes
// up_ready_o come straight from a flop (no dn_ready_i -> up_ready_o path).
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              up_valid_i,
    output logic              up_ready_o,
    input  logic [DATA_W-1:0] up_data_i,
    input  logic [CTRL_W-1:0] up_ctrl_i,
    input  logic              flush_i,
    output logic              dn_valid_o,
    input  logic              dn_ready_i,
    output logic [DATA_W-1:0] dn_data_o,
    output logic [CTRL_W-1:0] dn_ctrl_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    input  logic              cnt_clr_i
);

    localparam logic [CTRL_W-1:0] CTRL_ZERO = CTRL_W'(CTRL_BUBBLE);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
    logic              up_xfer;

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
    logic              main_free;

    assign up_ready_o = ~skid_valid_q;
    assign up_xfer    = up_valid_i & up_ready_o;
    // Main entry is either empty or being drained on this edge.
    assign main_free  = ~valid_q | dn_ready_i;

    // Main/skid next state: skid refills main first to keep FIFO order.
    always_comb begin
        valid_d      = valid_q;
        data_d       = data_q;
        ctrl_d       = ctrl_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_ctrl_d  = skid_ctrl_q;
        if (flush_i) begin
            valid_d      = 1'b0;
            ctrl_d       = CTRL_ZERO;
            skid_valid_d = 1'b0;
            skid_ctrl_d  = CTRL_ZERO;
        end else if (main_free) begin
            if (skid_valid_q) begin
                // up_ready_o is low here, so no upstream transfer competes.
                valid_d      = 1'b1;
                data_d       = skid_data_q;
                ctrl_d       = skid_ctrl_q;
                skid_valid_d = 1'b0;
                skid_ctrl_d  = CTRL_ZERO;
            end else if (up_xfer) begin
                valid_d = 1'b1;
                data_d  = up_data_i;
                ctrl_d  = up_ctrl_i;
            end else begin
                valid_d = 1'b0;
                ctrl_d  = CTRL_ZERO;
            end
        end else if (up_xfer) begin
            skid_valid_d = 1'b1;
            skid_data_d  = up_data_i;
            skid_ctrl_d  = up_ctrl_i;
        end
    end

    // Skid entry registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_ctrl_q  <= CTRL_ZERO;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_ctrl_q  <= skid_ctrl_d;
        end
    end
`else
    logic dn_xfer;

    assign up_ready_o = ~valid_q | dn_ready_i;
    assign up_xfer    = up_valid_i & up_ready_o;
    assign dn_xfer    = valid_q & dn_ready_i;

    // Main next state: flush, then capture, then bubble on drain, else hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        if (flush_i) begin
            valid_d = 1'b0;
            ctrl_d  = CTRL_ZERO;
        end else if (up_xfer) begin
            valid_d = 1'b1;
            data_d  = up_data_i;
            ctrl_d  = up_ctrl_i;
        end else if (dn_xfer) begin
            valid_d = 1'b0;
            ctrl_d  = CTRL_ZERO;
        end
    end
`endif

    // Main entry registers; payload is only cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= CTRL_ZERO;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
        end
    end

    pipe_stall_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (valid_q & ~dn_ready_i & ~flush_i),
        .clr_i (cnt_clr_i),
        .cnt_o (stall_cnt_o)
    );

    assign dn_valid_o = valid_q;
    assign dn_data_o  = data_q;
    assign dn_ctrl_o  = ctrl_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg (base or PIPE_STAGE_SKID_EN build).
module tb_pipe_stage_reg;

    localparam int DATA_W = 128;
    localparam int CTRL_W = 48;
    localparam int CNT_W  = 4;
    localparam int EW     = DATA_W + CTRL_W;
`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              up_valid_i;
    logic              up_ready_o;
    logic [DATA_W-1:0] up_data_i;
    logic [CTRL_W-1:0] up_ctrl_i;
    logic              flush_i;
    logic              dn_valid_o;
    logic              dn_ready_i;
    logic [DATA_W-1:0] dn_data_o;
    logic [CTRL_W-1:0] dn_ctrl_o;
    logic [CNT_W-1:0]  stall_cnt_o;
    logic              cnt_clr_i;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    pipe_stage_reg #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .up_valid_i  (up_valid_i),
        .up_ready_o  (up_ready_o),
        .up_data_i   (up_data_i),
        .up_ctrl_i   (up_ctrl_i),
        .flush_i     (flush_i),
        .dn_valid_o  (dn_valid_o),
        .dn_ready_i  (dn_ready_i),
        .dn_data_o   (dn_data_o),
        .dn_ctrl_o   (dn_ctrl_o),
        .stall_cnt_o (stall_cnt_o),
        .cnt_clr_i   (cnt_clr_i)
    );

    // ---------------- scoreboard ----------------
    logic [EW-1:0]    exp_q[$];   // {ctrl, data}, front = entry on dn_*
    logic [CNT_W-1:0] exp_cnt;
    int               n_tests;
    int               n_fail;

    task automatic check(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- driver ----------------
    // Called at a negedge: drive, check settled outputs against the model,
    // advance the model over the coming posedge, return at the next negedge.
    task automatic cycle(input logic uv, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                         input logic dr, input logic fl, input logic clr);
        logic          ev;
        logic          er;
        logic [EW-1:0] front;
        up_valid_i = uv;
        up_data_i  = d;
        up_ctrl_i  = c;
        dn_ready_i = dr;
        flush_i    = fl;
        cnt_clr_i  = clr;
        #1;
        ev    = (exp_q.size() != 0);
        front = ev ? exp_q[0] : '0;
        check("dn_valid", EW'(dn_valid_o), EW'(ev));
        check("dn_ctrl", EW'(dn_ctrl_o), EW'(front[EW-1:DATA_W]));
        if (ev) check("dn_data", EW'(dn_data_o), EW'(front[DATA_W-1:0]));
        er = SKID ? (exp_q.size() < 2) : (!ev || dr);
        check("up_ready", EW'(up_ready_o), EW'(er));
        check("stall_cnt", EW'(stall_cnt_o), EW'(exp_cnt));
        if (clr) exp_cnt = '0;
        else if (ev && !dr && !fl && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
        if (fl) begin
            exp_q.delete();
        end else begin
            if (ev && dr) void'(exp_q.pop_front());
            if (uv && er) exp_q.push_back({c, d});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic dr, input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, rand_data(), CTRL_W'($urandom), dr, 1'b0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_tests    = 0;
        n_fail     = 0;
        exp_cnt    = '0;
        rst_n      = 1'b0;
        up_valid_i = 1'b0;
        up_data_i  = '0;
        up_ctrl_i  = '0;
        flush_i    = 1'b0;
        dn_ready_i = 1'b0;
        cnt_clr_i  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", EW'(dn_valid_o), '0);
        check("rst_data", EW'(dn_data_o), '0);
        check("rst_ctrl", EW'(dn_ctrl_o), '0);
        check("rst_cnt", EW'(stall_cnt_o), '0);
        rst_n = 1'b1;

        // Streaming: ctrl 1..8 back to back, one per cycle.
        for (int i = 1; i <= 8; i++) cycle(1'b1, rand_data(), CTRL_W'(i), 1'b1, 1'b0, 1'b0);
        idle(1'b1, 2);
        check("stream_cnt", EW'(stall_cnt_o), '0);

        // Stall for 5 cycles while upstream keeps offering.
        cycle(1'b1, rand_data(), 48'h21, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) cycle(1'b1, rand_data(), CTRL_W'(8'h22 + k), 1'b0, 1'b0, 1'b0);
        check("stall_5", EW'(stall_cnt_o), EW'(5));
        idle(1'b1, 3);

        // Flush with a simultaneous upstream transfer.
        cycle(1'b1, rand_data(), 48'h33, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, rand_data(), 48'h12, 1'b1, 1'b1, 1'b0);
        check("flush_valid", EW'(dn_valid_o), '0);
        check("flush_ctrl", EW'(dn_ctrl_o), '0);
        // Flush while stalled (counter must not count the flush edge).
        cycle(1'b1, rand_data(), 48'h44, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, rand_data(), 48'h45, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, rand_data(), 48'h0, 1'b0, 1'b1, 1'b0);
        idle(1'b1, 2);

        // Reset mid-operation: outputs must clear without a clock edge.
        cycle(1'b1, {4{32'hA5A5_A5A5}}, 48'h3F, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, rand_data(), 48'h0, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", EW'(dn_valid_o), '0);
        check("arst_data", EW'(dn_data_o), '0);
        check("arst_ctrl", EW'(dn_ctrl_o), '0);
        check("arst_cnt", EW'(stall_cnt_o), '0);
        exp_q.delete();
        exp_cnt = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Saturation, then clear together with a stall.
        cycle(1'b1, rand_data(), 48'h55, 1'b1, 1'b0, 1'b0);
        idle(1'b0, 20);
        check("sat_15", EW'(stall_cnt_o), EW'(15));
        cycle(1'b0, rand_data(), 48'h0, 1'b0, 1'b0, 1'b1);
        check("clr_0", EW'(stall_cnt_o), '0);
        cycle(1'b0, rand_data(), 48'h0, 1'b0, 1'b0, 1'b0);
        check("clr_1", EW'(stall_cnt_o), EW'(1));
        cycle(1'b0, rand_data(), 48'h0, 1'b1, 1'b0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), rand_data(), {$urandom, 16'($urandom)},
                  1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0),
                  1'($urandom_range(0, 29) == 0));
        end
        idle(1'b1, 3);
        check("drained", EW'(exp_q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
